// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one polynomial multiplier between NREQ requesters.
// Packet-granular round-robin grant on the joint p/u beat stream; a tag FIFO
// remembers each packet's owner so the z result packets return in issue order.
// Optional build macro: MULT_ARB_LEN_CHECK_EN adds a per-packet beat-count
// check that raises the sticky err flag on short or long packets.
module mult_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned N    = 4,
    parameter int unsigned QW   = 5,
    parameter int unsigned UW   = 1,
    parameter int unsigned TAGD = 4
) (
    input  logic               clk,
    input  logic               s_rst,
    input  logic [NREQ*QW-1:0] s_p_data,
    input  logic [NREQ*UW-1:0] s_u_data,
    input  logic [NREQ-1:0]    s_vld,
    input  logic [NREQ-1:0]    s_last,
    output logic [NREQ-1:0]    s_rdy,
    output logic [QW-1:0]      m_p_data,
    output logic [UW-1:0]      m_u_data,
    output logic               m_vld,
    output logic               m_last,
    input  logic               m_rdy,
    input  logic [QW-1:0]      r_data,
    input  logic               r_vld,
    input  logic               r_last,
    output logic               r_rdy,
    output logic [QW-1:0]      z_data,
    output logic [NREQ-1:0]    z_vld,
    output logic               z_last,
    input  logic [NREQ-1:0]    z_rdy,
    output logic               busy,
    output logic               err
);

    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = (TAGD > 1) ? $clog2(TAGD) : 1;
    localparam int unsigned CW = $clog2(TAGD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_ptr;
    logic [OW-1:0]     rr_next;
    logic              started;

    logic [OW-1:0]     tag_mem [TAGD];
    logic [TW-1:0]     wr_ptr;
    logic [TW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [OW-1:0]     head;
    logic              tag_empty;
    logic              tag_full;

    logic [2*NREQ-1:0] vld_dbl;
    logic              any_vld;
    logic [OW-1:0]     winner;

    logic              fire;
    logic              push;
    logic              pop;

`ifdef MULT_ARB_LEN_CHECK_EN
    localparam int unsigned BW = $clog2(N + 1);
    logic [BW-1:0]     beat_cnt;
    logic [BW-1:0]     beat_n;
    assign beat_n = beat_cnt + BW'(1);
`endif

    assign tag_empty = (count == CW'(0));
    assign tag_full  = (count == CW'(TAGD));
    assign head      = tag_mem[rd_ptr];
    assign busy      = (state == GRANT) || !tag_empty;

    // Rotate valids so that bit 0 corresponds to the round-robin pointer.
    assign vld_dbl = {s_vld, s_vld} >> rr_ptr;
    assign any_vld = |s_vld;
    assign rr_next = (owner == OW'(NREQ - 1)) ? OW'(0) : owner + OW'(1);

    // Round-robin winner: first valid requester at or after rr_ptr.
    always_comb begin
        int   sum;
        logic found;
        sum    = 0;
        found  = 1'b0;
        winner = rr_ptr;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && vld_dbl[k]) begin
                found = 1'b1;
                sum   = int'(rr_ptr) + k;
                if (sum >= int'(NREQ)) begin
                    sum = sum - int'(NREQ);
                end
                winner = OW'(sum);
            end
        end
    end

    // Forward the owner's beat stream to the multiplier while granted.
    always_comb begin
        m_p_data = '0;
        m_u_data = '0;
        m_vld    = 1'b0;
        m_last   = 1'b0;
        s_rdy    = '0;
        if (state == GRANT) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                if (owner == OW'(k)) begin
                    m_p_data = s_p_data[k*QW +: QW];
                    m_u_data = s_u_data[k*UW +: UW];
                    m_vld    = s_vld[k];
                    m_last   = s_last[k];
                    s_rdy[k] = m_rdy;
                end
            end
        end
    end

    // Route multiplier results to the requester named by the head tag.
    always_comb begin
        z_vld  = '0;
        r_rdy  = 1'b0;
        z_data = r_data;
        z_last = r_last && !tag_empty;
        if (!tag_empty) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                if (head == OW'(k)) begin
                    z_vld[k] = r_vld;
                    r_rdy    = z_rdy[k];
                end
            end
        end
    end

    assign fire = m_vld && m_rdy;
    assign push = fire && !started;
    assign pop  = r_vld && r_rdy && r_last;

    // Grant FSM, round-robin pointer, tag FIFO and sticky error flag.
    always_ff @(posedge clk or posedge s_rst) begin
        if (s_rst) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            started <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
            for (int i = 0; i < int'(TAGD); i++) begin
                tag_mem[i] <= '0;
            end
`ifdef MULT_ARB_LEN_CHECK_EN
            beat_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    started <= 1'b0;
                    if (any_vld && !tag_full) begin
                        owner <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (fire) begin
                        started <= 1'b1;
                        if (m_last) begin
                            rr_ptr  <= rr_next;
                            started <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tag_mem[wr_ptr] <= owner;
                wr_ptr          <= wr_ptr + TW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            // A result with no outstanding tag has nowhere to go.
            if (r_vld && tag_empty) begin
                err <= 1'b1;
            end

`ifdef MULT_ARB_LEN_CHECK_EN
            // Packet length must be exactly N beats.
            if (fire) begin
                if (m_last && (beat_n != BW'(N))) begin
                    err <= 1'b1;
                end
                if (!m_last && (beat_n == BW'(N))) begin
                    err <= 1'b1;
                end
                if (m_last) begin
                    beat_cnt <= '0;
                end else if (beat_cnt != BW'(N)) begin
                    beat_cnt <= beat_n;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (NREQ=2, N=4, QW=5, UW=1, TAGD=4).
module tb_mult_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned N    = 4;
    localparam int unsigned QW   = 5;
    localparam int unsigned UW   = 1;
    localparam int unsigned TAGD = 4;

    logic               clk = 1'b0;
    logic               s_rst;
    logic [NREQ*QW-1:0] s_p_data;
    logic [NREQ*UW-1:0] s_u_data;
    logic [NREQ-1:0]    s_vld;
    logic [NREQ-1:0]    s_last;
    logic [NREQ-1:0]    s_rdy;
    logic [QW-1:0]      m_p_data;
    logic [UW-1:0]      m_u_data;
    logic               m_vld;
    logic               m_last;
    logic               m_rdy;
    logic [QW-1:0]      r_data;
    logic               r_vld;
    logic               r_last;
    logic               r_rdy;
    logic [QW-1:0]      z_data;
    logic [NREQ-1:0]    z_vld;
    logic               z_last;
    logic [NREQ-1:0]    z_rdy;
    logic               busy;
    logic               err;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(
        .NREQ(NREQ), .N(N), .QW(QW), .UW(UW), .TAGD(TAGD)
    ) dut (
        .clk(clk), .s_rst(s_rst),
        .s_p_data(s_p_data), .s_u_data(s_u_data), .s_vld(s_vld), .s_last(s_last), .s_rdy(s_rdy),
        .m_p_data(m_p_data), .m_u_data(m_u_data), .m_vld(m_vld), .m_last(m_last), .m_rdy(m_rdy),
        .r_data(r_data), .r_vld(r_vld), .r_last(r_last), .r_rdy(r_rdy),
        .z_data(z_data), .z_vld(z_vld), .z_last(z_last), .z_rdy(z_rdy),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        s_p_data = '0;
        s_u_data = '0;
        s_vld    = '0;
        s_last   = '0;
        m_rdy    = 1'b1;
        r_data   = '0;
        r_vld    = 1'b0;
        r_last   = 1'b0;
        z_rdy    = '1;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        s_rst = 1'b0;
    endtask

    logic [QW-1:0]   pv [4];
    logic [NREQ-1:0] rdy_seq [9];
    logic [NREQ-1:0] head_seq [3];

    initial begin
        pv       = '{5'd30, 5'd8, 5'd31, 5'd4};
        rdy_seq  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        head_seq = '{2'b01, 2'b10, 2'b01};

        // Reset values
        s_rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_s_rdy", 32'(s_rdy), 32'd0);
        chk("rst_m_vld", 32'(m_vld), 32'd0);
        chk("rst_r_rdy", 32'(r_rdy), 32'd0);
        chk("rst_z_vld", 32'(z_vld), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        @(negedge clk);
        s_rst = 1'b0;

        // Single 4-beat packet from requester 0, echoed result
        @(negedge clk);
        s_vld = 2'b01;
        s_u_data = '1;
        s_p_data[QW-1:0] = pv[0];
        #1;
        chk("t1_decide_idle", 32'(m_vld), 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_p_data[QW-1:0] = pv[b];
            s_last = (b == 3) ? 2'b01 : 2'b00;
            #1;
            chk("t1_m_p_data", 32'(m_p_data), 32'(pv[b]));
            chk("t1_m_last",   32'(m_last),   (b == 3) ? 32'd1 : 32'd0);
            chk("t1_s_rdy",    32'(s_rdy),    32'd1);
            chk("t1_m_u_data", 32'(m_u_data), 32'd1);
        end
        @(negedge clk);
        s_vld  = '0;
        s_last = '0;
        #1;
        chk("t1_after_m_vld", 32'(m_vld), 32'd0);
        chk("t1_busy_tag",    32'(busy),  32'd1);
        chk("t1_z_idle",      32'(z_vld), 32'd0);
        for (int b = 0; b < 4; b++) begin
            r_vld  = 1'b1;
            r_data = pv[b];
            r_last = (b == 3);
            #1;
            chk("t1_z_vld",  32'(z_vld),  32'b01);
            chk("t1_z_data", 32'(z_data), 32'(pv[b]));
            chk("t1_z_last", 32'(z_last), (b == 3) ? 32'd1 : 32'd0);
            chk("t1_r_rdy",  32'(r_rdy),  32'd1);
            @(negedge clk);
        end
        r_vld  = 1'b0;
        r_last = 1'b0;
        #1;
        chk("t1_busy_done", 32'(busy), 32'd0);

        // Both requesters contend: 0,1,0,1 with one idle cycle, then FIFO full
        do_reset();
        s_p_data = {5'd2, 5'd1};
        s_vld    = 2'b11;
        s_last   = 2'b11;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            #1;
            chk("t2_s_rdy_seq", 32'(s_rdy), 32'(rdy_seq[c]));
            if (rdy_seq[c] == 2'b01) chk("t2_m_p0", 32'(m_p_data), 32'd1);
            if (rdy_seq[c] == 2'b10) chk("t2_m_p1", 32'(m_p_data), 32'd2);
        end
        chk("t2_busy_full", 32'(busy), 32'd1);

        // First result pops a tag; fifth packet granted right after
        @(negedge clk);
        r_vld  = 1'b1;
        r_last = 1'b1;
        r_data = 5'd9;
        #1;
        chk("t3_z_vld_head0", 32'(z_vld), 32'b01);
        chk("t3_still_full",  32'(s_rdy), 32'd0);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("t3_decide_cycle", 32'(s_rdy), 32'd0);
        @(negedge clk);
        #1;
        chk("t3_fifth_grant", 32'(s_rdy), 32'b01);

        // Requester 1 stalls its result for 3 cycles
        @(negedge clk);
        s_vld  = '0;
        s_last = '0;
        r_vld  = 1'b1;
        r_last = 1'b1;
        r_data = 5'd21;
        z_rdy  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_z_vld", 32'(z_vld),  32'b10);
            chk("t4_stall_r_rdy", 32'(r_rdy),  32'd0);
            chk("t4_stall_data",  32'(z_data), 32'd21);
            @(negedge clk);
        end
        z_rdy = 2'b11;
        #1;
        chk("t4_release_r_rdy", 32'(r_rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r_data = QW'(i);
            #1;
            chk("t4_drain_order", 32'(z_vld), 32'(head_seq[i]));
        end
        @(negedge clk);
        r_vld  = 1'b0;
        r_last = 1'b0;
        #1;
        chk("t4_busy_idle", 32'(busy), 32'd0);
`ifndef MULT_ARB_LEN_CHECK_EN
        chk("t4_err_clean", 32'(err), 32'd0);
`endif

        // Stray result with no tag is refused and sets sticky err
        @(negedge clk);
        r_vld = 1'b1;
        #1;
        chk("stray_r_rdy", 32'(r_rdy), 32'd0);
        chk("stray_z_vld", 32'(z_vld), 32'd0);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("stray_err_set", 32'(err), 32'd1);
        @(negedge clk);
        #1;
        chk("stray_err_sticky", 32'(err), 32'd1);

        // Reset mid-packet; pointer returns to requester 0
        do_reset();
        s_p_data = {5'd17, 5'd3};
        s_vld    = 2'b01;
        s_last   = 2'b01;
        @(negedge clk);
        #1;
        chk("t5_grant0", 32'(s_rdy), 32'b01);
        @(negedge clk);
        s_vld  = 2'b11;
        s_last = 2'b00;
        #1;
        chk("t5_gap", 32'(s_rdy), 32'd0);
        @(negedge clk);
        #1;
        chk("t5_grant1",  32'(s_rdy),    32'b10);
        chk("t5_m_p1",    32'(m_p_data), 32'd17);
        @(negedge clk);
        #1;
        chk("t5_beat2",   32'(s_rdy),    32'b10);
        @(negedge clk);
        s_rst = 1'b1;
        #1;
        chk("t5_rst_s_rdy", 32'(s_rdy), 32'd0);
        chk("t5_rst_m_vld", 32'(m_vld), 32'd0);
        chk("t5_rst_busy",  32'(busy),  32'd0);
        chk("t5_rst_z_vld", 32'(z_vld), 32'd0);
        chk("t5_rst_r_rdy", 32'(r_rdy), 32'd0);
        chk("t5_rst_err",   32'(err),   32'd0);
        @(negedge clk);
        s_rst = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_regrant0", 32'(s_rdy), 32'b01);

`ifdef MULT_ARB_LEN_CHECK_EN
        // Short 3-beat packet flags a length error
        do_reset();
        s_vld = 2'b01;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            s_last = (b == 2) ? 2'b01 : 2'b00;
            @(negedge clk);
        end
        s_vld  = '0;
        s_last = '0;
        #1;
        chk("len_err_set", 32'(err), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("len_err_sticky", 32'(err), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
